// File: rtl/code_key_pkg.sv
// -----------------------------------------------------------------------------
// code_key_pkg
// Shared definitions for the code-key transmitter: frame FSM states, frame
// geometry and the key word accepted by the key-lock detector.
// -----------------------------------------------------------------------------
package code_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // START + 8 data bits + STOP
    localparam int         FRAME_ELEMS = 10;
    localparam int         DATA_BITS   = 8;
    localparam logic [7:0] KEY_CODE    = 8'hBD;

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Element period timer for the code-key transmitter. A 3-bit down-counter is
// reloaded with P-1 (P = 2^div) at each frame element boundary and then counts
// down to zero, where it holds.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset (counter to 0)
//   reload - load P-1 for the element that starts next cycle
//   div    - period select used on reload (P = 1, 2, 4, 8)
//   tick   - high in the last cycle of the current period
// -----------------------------------------------------------------------------
module bit_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       reload,
    input  logic [1:0] div,
    output logic       tick
);

    logic [2:0] r_cnt;
    logic [2:0] w_period_m1;

    always_comb begin
        w_period_m1 = 3'd0;
        case (div)
            2'd0:    w_period_m1 = 3'd0;
            2'd1:    w_period_m1 = 3'd1;
            2'd2:    w_period_m1 = 3'd3;
            default: w_period_m1 = 3'd7;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (reload) begin
            r_cnt <= w_period_m1;
        end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign tick = (r_cnt == 3'd0);

endmodule

// File: rtl/code_key_transmitter.sv
// -----------------------------------------------------------------------------
// code_key_transmitter
// Serial key-word transmitter. On a start rising edge it sends a frame
// START(0), 8 data bits LSB first, STOP(1), each element lasting P = 2^div
// cycles. The key word can be reloaded serially while idle.
//
// Ports:
//   io_in[0]   clk         io_in[1] rst (async, active-high)
//   io_in[2]   start       io_in[3] shift_en
//   io_in[4]   shift_data  io_in[5] repeat
//   io_in[7:6] div
//   io_out[0]  tx          io_out[1] busy
//   io_out[2]  done        io_out[3] bit_strobe
//   io_out[7:4] bit_index (1..8 during data bits, else 0)
// -----------------------------------------------------------------------------
module code_key_transmitter
    import code_key_pkg::*;
#(
    parameter logic [7:0] DEFAULT_CODE = KEY_CODE
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       w_clk;
    logic       w_rst;
    logic       w_start;
    logic       w_shift_en;
    logic       w_shift_data;
    logic       w_repeat;
    logic [1:0] w_div;

    assign w_clk        = io_in[0];
    assign w_rst        = io_in[1];
    assign w_start      = io_in[2];
    assign w_shift_en   = io_in[3];
    assign w_shift_data = io_in[4];
    assign w_repeat     = io_in[5];
    assign w_div        = io_in[7:6];

    state_t     r_state, w_state_next;
    logic       r_start_q;
    logic [7:0] r_code, w_code_next;
    logic [7:0] r_shift, w_shift_next;
    logic [2:0] r_bit, w_bit_next;
    logic [1:0] r_div, w_div_next;
    logic       r_done, w_done_next;
    logic       r_strobe, w_strobe_next;

    logic       w_start_edge;
    logic       w_tick;
    logic       w_reload;
    logic       w_enter;
    logic [1:0] w_timer_div;
    logic       w_tx;
    logic       w_busy;
    logic [3:0] w_idx;

    assign w_start_edge = w_start & ~r_start_q;

    // The timer must see the freshly selected div on the frame-entry edge,
    // because r_div only takes that value on the same edge.
    assign w_timer_div = w_enter ? w_div : r_div;

    bit_timer u_bit_timer (
        .clk    (w_clk),
        .rst    (w_rst),
        .reload (w_reload),
        .div    (w_timer_div),
        .tick   (w_tick)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_code    <= DEFAULT_CODE;
            r_shift   <= 8'd0;
            r_bit     <= 3'd0;
            r_div     <= 2'd0;
            r_done    <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_start_q <= w_start;
            r_code    <= w_code_next;
            r_shift   <= w_shift_next;
            r_bit     <= w_bit_next;
            r_div     <= w_div_next;
            r_done    <= w_done_next;
            r_strobe  <= w_strobe_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_code_next   = r_code;
        w_shift_next  = r_shift;
        w_bit_next    = r_bit;
        w_div_next    = r_div;
        w_done_next   = 1'b0;
        w_strobe_next = 1'b0;
        w_enter       = 1'b0;
        w_reload      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A start edge takes priority over a serial load in the same cycle.
                if (w_start_edge) begin
                    w_enter      = 1'b1;
                    w_state_next = ST_START;
                end else if (w_shift_en) begin
                    w_code_next = {w_shift_data, r_code[7:1]};
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next  = ST_DATA;
                    w_bit_next    = 3'd0;
                    w_strobe_next = 1'b1;
                    w_reload      = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_reload = 1'b1;
                    if (r_bit == 3'(DATA_BITS - 1)) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next    = r_bit + 3'd1;
                        w_shift_next  = {1'b0, r_shift[7:1]};
                        w_strobe_next = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_done_next = 1'b1;
                    if (w_repeat) begin
                        w_enter      = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_enter) begin
            w_shift_next = r_code;
            w_div_next   = w_div;
            w_reload     = 1'b1;
        end
    end

    always_comb begin
        w_tx   = 1'b1;
        w_busy = 1'b1;
        w_idx  = 4'd0;
        case (r_state)
            ST_IDLE:  w_busy = 1'b0;
            ST_START: w_tx   = 1'b0;
            ST_DATA: begin
                w_tx  = r_shift[0];
                w_idx = {1'b0, r_bit} + 4'd1;
            end
            default:  w_tx   = 1'b1;
        endcase
    end

    assign io_out = {w_idx, r_strobe, r_done, w_busy, w_tx};

endmodule

// File: tb/tb_code_key_transmitter.sv
// -----------------------------------------------------------------------------
// tb_code_key_transmitter
// Self-checking bench for code_key_transmitter: a frame-position model
// predicts every output each cycle, and directed scenarios add literal
// expectations for the waveforms.
// -----------------------------------------------------------------------------
module tb_code_key_transmitter;
    import code_key_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       shen = 1'b0;
    logic       shdata = 1'b0;
    logic       rpt = 1'b0;
    logic [1:0] div = 2'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {div, rpt, shdata, shen, start, rst, clk};

    code_key_transmitter #(.DEFAULT_CODE(8'hBD)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: position within the frame ----------
    bit         m_busy = 1'b0;
    bit         m_start_q = 1'b0;
    bit         m_done = 1'b0;
    int         m_t = 0;
    int         m_P = 1;
    logic [7:0] m_code = 8'hBD;
    logic [7:0] m_frame = 8'h00;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_start_q = 0; m_done = 0;
                m_t = 0; m_P = 1; m_code = 8'hBD; m_frame = 8'h00;
            end else begin
                m_done = 0;
                if (m_busy) begin
                    m_t++;
                    if (m_t == FRAME_ELEMS * m_P) begin
                        m_done = 1;
                        if (rpt) begin
                            m_t = 0; m_frame = m_code; m_P = 1 << div;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end else if (start && !m_start_q) begin
                    m_busy = 1; m_t = 0; m_frame = m_code; m_P = 1 << div;
                end else if (shen) begin
                    m_code = {shdata, m_code[7:1]};
                end
                m_start_q = start;
            end
        end
    end

    int   e_m, ph_m;
    logic x_tx, x_strobe;
    logic [3:0] x_idx;

    always @(negedge clk) begin
        if (chk_en) begin
            x_tx = 1'b1; x_idx = 4'd0; x_strobe = 1'b0;
            if (m_busy) begin
                e_m  = m_t / m_P;
                ph_m = m_t % m_P;
                if (e_m == 0) x_tx = 1'b0;
                else if (e_m <= DATA_BITS) begin
                    x_tx     = m_frame[e_m-1];
                    x_idx    = 4'(e_m);
                    x_strobe = (ph_m == 0);
                end
            end
            chk("tx",        io_out[0],   x_tx);
            chk("busy",      io_out[1],   m_busy);
            chk("done",      io_out[2],   m_done);
            chk("strobe",    io_out[3],   x_strobe);
            chk("bit_index", io_out[7:4], x_idx);
        end
    end

    // ---------------- observation helpers ----------------
    int   oc;
    logic tx_log   [0:255];
    logic busy_log [0:255];
    int   idx_log  [0:255];
    int   nbusy;
    int   strobe_pos[$];
    int   done_pos[$];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic obs_reset();
        oc = 0; nbusy = 0;
        strobe_pos.delete();
        done_pos.delete();
    endtask

    task automatic obs(input int n);
        repeat (n) begin
            step();
            oc++;
            tx_log[oc]   = io_out[0];
            busy_log[oc] = io_out[1];
            idx_log[oc]  = int'(io_out[7:4]);
            if (io_out[1]) nbusy++;
            if (io_out[3]) strobe_pos.push_back(oc);
            if (io_out[2]) done_pos.push_back(oc);
        end
    endtask

    // frame of P=1 starting at observed cycle 1: tx at cycles 1..10
    task automatic chk_frame10(input string nm, input logic [9:0] exp);
        logic [9:0] act;
        act = '0;
        for (int i = 1; i <= 10; i++) act = {act[8:0], tx_log[i]};
        chk(nm, act, exp);
    endtask

    task automatic frame_div0(input string nm, input logic [9:0] exp);
        div = 2'd0; start = 1'b1;
        obs_reset();
        obs(12);
        start = 1'b0;
        chk_frame10(nm, exp);
        chk({nm, "_busy"}, nbusy, 10);
        chk({nm, "_ndone"}, done_pos.size(), 1);
        if (done_pos.size() > 0) chk({nm, "_done_at"}, done_pos[0], 11);
        step();
    endtask

    localparam logic [9:0] TX_BD = 10'b0101111011;

    initial begin
        // reset
        rst = 1'b1;
        step(); step();
        chk_en = 1'b1;
        chk("reset_out", io_out, 8'h01);
        rst = 1'b0;
        step(); step();

        // div=0 frame of the default key
        div = 2'd0; start = 1'b1;
        obs_reset();
        obs(12);
        start = 1'b0;
        chk_frame10("tx_bd", TX_BD);
        chk("busy10", nbusy, 10);
        chk("done_at11", (done_pos.size() == 1) ? done_pos[0] : -1, 11);
        for (int k = 1; k <= 8; k++) chk("bit_index_seq", idx_log[k+1], k);
        chk("idx_stop", idx_log[10], 0);
        step(); step();

        // div=3 frame
        div = 2'd3; start = 1'b1;
        obs_reset();
        step(); start = 1'b0; div = 2'd0;
        oc = 0;
        obs(84);
        chk("busy80", nbusy, 79);
        chk("nstrobe", strobe_pos.size(), 8);
        if (strobe_pos.size() > 0) chk("strobe_first", strobe_pos[0], 8);
        for (int i = 1; i < strobe_pos.size(); i++)
            chk("strobe_gap", strobe_pos[i] - strobe_pos[i-1], 8);
        for (int i = 1; i <= 7; i++) chk("start_low", tx_log[i], 1'b0);
        step(); step();

        // serial load 0x5A
        shen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'b01011010;
            shdata = pat[7-i];
            step();
        end
        shen = 1'b0; shdata = 1'b0;
        step();
        frame_div0("tx_5a", 10'b0010110101);

        // repeat, div=1: two 20-cycle frames
        div = 2'd1; rpt = 1'b1; start = 1'b1;
        obs_reset();
        obs(25);
        rpt = 1'b0; start = 1'b0;
        obs(20);
        chk("rep_busy", nbusy, 40);
        chk("rep_ndone", done_pos.size(), 2);
        if (done_pos.size() == 2) begin
            chk("rep_done1", done_pos[0], 21);
            chk("rep_done2", done_pos[1], 41);
        end
        chk("rep_busy20", busy_log[20], 1'b1);
        chk("rep_busy21", busy_log[21], 1'b1);
        chk("rep_idle41", busy_log[41], 1'b0);
        step();

        // reset during data bit 4
        div = 2'd0; start = 1'b1;
        obs_reset();
        obs(5);
        start = 1'b0;
        chk("idx_before_rst", idx_log[5], 4);
        rst = 1'b1;
        #1;
        chk("async_rst", io_out, 8'h01);
        step();
        rst = 1'b0;
        step(); step();
        frame_div0("tx_after_rst", TX_BD);

        // start toggles and shifts during a frame are ignored
        div = 2'd2; start = 1'b1;
        obs_reset();
        obs(3);
        start = 1'b0; shen = 1'b1; shdata = 1'b0;
        obs(3);
        start = 1'b1;
        obs(3);
        start = 1'b0;
        obs(11);
        shen = 1'b0;
        obs(24);
        chk("ign_busy", nbusy, 40);
        chk("ign_ndone", done_pos.size(), 1);
        step();
        frame_div0("tx_unchanged", TX_BD);

        // simultaneous start edge and shift: pre-shift code is sent
        div = 2'd0; start = 1'b1; shen = 1'b1; shdata = 1'b0;
        obs_reset();
        obs(1);
        shen = 1'b0;
        obs(11);
        start = 1'b0;
        chk_frame10("tx_preshift", TX_BD);
        step();
        frame_div0("tx_code_kept", TX_BD);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step();
            rst    = ($urandom_range(0, 199) == 0);
            start  = ($urandom_range(0, 3) == 0);
            shen   = ($urandom_range(0, 1) == 0);
            shdata = 1'($urandom_range(0, 1));
            rpt    = ($urandom_range(0, 4) == 0);
            div    = 2'($urandom_range(0, 3));
        end
        rst = 1'b0; start = 1'b0; shen = 1'b0; rpt = 1'b0;
        repeat (100) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/code_key_transmitter.md
CODE_KEY_TRANSMITTER -- requirements
Module: code_key_transmitter

Interface
REQ-001 SHALL have a parameter DEFAULT_CODE, default 8'hBD, giving the key word loaded at reset; 8'hBD is the word the team's key-lock detector accepts.
REQ-002 SHALL have io_in  input  8: bundled inputs, bit fields per REQ-003..REQ-009.
REQ-003 SHALL use io_in[0]  input  1  as the clock; it is the only clock, and all state updates on its rising edge.
REQ-004 SHALL use io_in[1]  input  1  as reset, asynchronous and active-high.
REQ-005 SHALL use io_in[2]  input  1  as start; a rising edge requests one frame.
REQ-006 SHALL use io_in[3]  input  1  as shift_en, the code-register serial load enable.
REQ-007 SHALL use io_in[4]  input  1  as shift_data, the serial load bit.
REQ-008 SHALL use io_in[5]  input  1  as repeat; when high, the next frame follows the current one back-to-back.
REQ-009 SHALL use io_in[7:6]  input  2  as div, selecting bit period P = 2^div cycles (1, 2, 4 or 8).
REQ-010 SHALL have io_out  output  8: [0] tx, [1] busy, [2] done, [3] bit_strobe, [7:4] bit_index.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-012 SHALL, in IDLE, drive tx=1, busy=0 and bit_index=0.
REQ-013 SHALL register start every cycle as start_q, and detect a start edge as start=1 and start_q=0.
REQ-014 SHALL, on a start edge sampled in IDLE at clock edge N, enter START at edge N so that tx=0 and busy=1 from cycle N+1.
REQ-015 SHALL, on frame entry, copy the code register into a shift register and latch div; later changes to div do not affect the frame.
REQ-016 SHALL hold each frame element for exactly P cycles: START (tx=0), 8 DATA bits LSB first, STOP (tx=1), giving 10P busy cycles per frame.
REQ-017 SHALL drive bit_index = k (1..8) during data bit k, and 0 in START, STOP and IDLE.
REQ-018 SHALL pulse bit_strobe high for exactly the first cycle of each data bit, and keep it low otherwise.
REQ-019 SHALL, at the end of STOP, pulse done high for 1 cycle, in the first cycle of the following state.
REQ-020 SHALL, when repeat=1 at the end of STOP, go directly to START with busy held at 1 and done still pulsed, re-copying the code register and re-latching div.
REQ-021 SHALL, when repeat=0 at the end of STOP, return to IDLE.
REQ-022 SHALL ignore start edges while busy; an ignored edge is not queued.
REQ-023 SHALL, in IDLE with shift_en=1 and no start edge, update code <= {shift_data, code[7:1]} each cycle, so that 8 shifts load a word LSB first.
REQ-024 SHALL ignore shift_en while busy.
REQ-025 SHALL, on a start edge and shift_en in the same IDLE cycle, let start win: no shift, and the frame uses the pre-shift code.
REQ-026 SHALL time bits with a down-counter of width 3, reloaded with P-1 at each element boundary.

Reset
REQ-027 SHALL, while reset is high, asynchronously force: state=IDLE, tx=1, busy=0, done=0, bit_strobe=0, bit_index=0, start_q=0, code=DEFAULT_CODE, shift register=0, bit counter=0, latched div=0.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately with no done pulse, and not resume it after reset release.

Structure
REQ-029 SHALL place the state enum, FRAME_ELEMS=10, DATA_BITS=8 and KEY_CODE=8'hBD in shared package code_key_pkg.
REQ-030 SHALL implement bit timing in one sub-module, bit_timer, with inputs clk, rst, reload and div, and output tick (last cycle of the period).
REQ-031 SHALL keep the FSM, code register and shift register in code_key_transmitter.

Verification
REQ-032 SHALL cover: reset, div=0, start edge -> tx = 0,1,0,1,1,1,1,0,1,1 on consecutive cycles, busy=1 for 10 cycles, done pulse in cycle 11, bit_index 1..8.
REQ-033 SHALL cover: div=3, start -> each tx level held 8 cycles, busy=1 for 80 cycles, bit_strobe pulses exactly 8 times, 8 cycles apart.
REQ-034 SHALL cover: idle, shift_en=1 with shift_data 0,1,0,1,1,0,1,0 over 8 cycles, then start -> data bits 0,1,0,1,1,0,1,0 (0x5A).
REQ-035 SHALL cover: repeat=1, div=1, start -> two 20-cycle frames with no idle gap, done pulses at cycles 21 and 41, busy stays 1; repeat dropped during the second frame -> IDLE after it.
REQ-036 SHALL cover: reset asserted during data bit 4 -> tx=1, busy=0, bit_index=0 without a clock edge, no done pulse, code=0xBD afterwards.
REQ-037 SHALL cover: start toggled and shift_en=1 during a frame -> frame unchanged, no second frame, code unchanged; simultaneous start edge and shift in IDLE -> frame sends the pre-shift code.
